hist_ram_sched: RTL and testbench

//  Scheduler/arbiter in front of pipeline_ram (the pipelined read-modify-write histogram RAM).

---
 rtl/hist_ram_sched.sv | 192 +++++++++++++++++++
 tb/tb_hist_ram_sched.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hist_ram_sched.sv
// Round-robin scheduler for pipeline_ram's single increment port, plus clear-all/dump-all sweeps.
// Grants are combinational (0 cycles), one per cycle; requesters hold until req_ready; sweeps stall all grants.
module hist_ram_sched #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16,
  parameter int RD_LAT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_bin,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     clr_start,
  input  logic                     dump_start,
  output logic                     busy,
  output logic                     done,
  output logic                     ram_en,
  output logic                     ram_clr,
  output logic                     ram_rd,
  output logic [ADDR_W-1:0]        ram_addr,
  input  logic [CNT_W-1:0]         ram_rdata,
  output logic                     dump_valid,
  output logic [ADDR_W-1:0]        dump_bin,
  output logic [CNT_W-1:0]         dump_data
);

  localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WCNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = {ADDR_W{1'b1}};
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(NREQ - 1);

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_DRAIN = 3'd1,
    ST_CLEAR = 3'd2,
    ST_DUMP  = 3'd3,
    ST_FLUSH = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                sweep_clr_q, sweep_clr_d;
  logic                done_q, done_d;
  logic [RD_LAT-1:0]   dv_q, dv_d;
  logic [ADDR_W-1:0]   db_q [RD_LAT];
  logic [ADDR_W-1:0]   db_d [RD_LAT];

  logic                gnt_vld;
  logic [PTR_W-1:0]    gnt_idx;
  logic [PTR_W-1:0]    cand;
  logic [NREQ-1:0]     rdy_c;
  logic                en_c, clr_c, rd_c;
  logic [ADDR_W-1:0]   addr_c;

  // Circular search starting at rr_ptr; first valid requester wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PTR_W'((int'(rr_ptr_q) + k) % NREQ);
      if (!gnt_vld && req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wcnt_d      = wcnt_q;
    rr_ptr_d    = rr_ptr_q;
    sweep_clr_d = sweep_clr_q;
    done_d      = 1'b0;
    rdy_c       = '0;
    en_c        = 1'b0;
    clr_c       = 1'b0;
    rd_c        = 1'b0;
    addr_c      = '0;

    case (state_q)
      ST_RUN: begin
        // A command cycle grants nothing; clear takes priority over dump.
        if (clr_start || dump_start) begin
          state_d     = ST_DRAIN;
          wcnt_d      = '0;
          sweep_clr_d = clr_start;
        end else if (gnt_vld) begin
          rdy_c[gnt_idx] = 1'b1;
          en_c           = 1'b1;
          addr_c         = req_bin[gnt_idx*ADDR_W +: ADDR_W];
          rr_ptr_d       = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + 1'b1;
        end
      end
      ST_DRAIN: begin
        wcnt_d = wcnt_q + 1'b1;
        if (wcnt_q == WCNT_LAST) begin
          state_d = sweep_clr_q ? ST_CLEAR : ST_DUMP;
          idx_d   = '0;
        end
      end
      ST_CLEAR: begin
        clr_c  = 1'b1;
        addr_c = idx_q;
        idx_d  = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = ST_RUN;
          done_d  = 1'b1;
        end
      end
      ST_DUMP: begin
        rd_c   = 1'b1;
        addr_c = idx_q;
        idx_d  = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = ST_FLUSH;
          wcnt_d  = '0;
        end
      end
      ST_FLUSH: begin
        wcnt_d = wcnt_q + 1'b1;
        if (wcnt_q == WCNT_LAST) begin
          state_d = ST_RUN;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Reset silences every strobe in the same cycle, aborting any sweep at once.
    if (rst) begin
      rdy_c  = '0;
      en_c   = 1'b0;
      clr_c  = 1'b0;
      rd_c   = 1'b0;
      addr_c = '0;
    end
  end

  // Dump beat tracking mirrors the RAM read latency.
  always_comb begin
    dv_d[0] = rd_c;
    db_d[0] = rd_c ? addr_c : '0;
    for (int i = 1; i < RD_LAT; i++) begin
      dv_d[i] = dv_q[i-1];
      db_d[i] = db_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      idx_q       <= '0;
      wcnt_q      <= '0;
      rr_ptr_q    <= '0;
      sweep_clr_q <= 1'b0;
      done_q      <= 1'b0;
      dv_q        <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        db_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wcnt_q      <= wcnt_d;
      rr_ptr_q    <= rr_ptr_d;
      sweep_clr_q <= sweep_clr_d;
      done_q      <= done_d;
      dv_q        <= dv_d;
      db_q        <= db_d;
    end
  end

  assign req_ready  = rdy_c;
  assign ram_en     = en_c;
  assign ram_clr    = clr_c;
  assign ram_rd     = rd_c;
  assign ram_addr   = addr_c;
  assign busy       = !rst && (state_q != ST_RUN);
  assign done       = !rst && done_q;
  assign dump_valid = dv_q[RD_LAT-1];
  assign dump_bin   = db_q[RD_LAT-1];
  assign dump_data  = dump_valid ? ram_rdata : '0;

endmodule

// File: tb/tb_hist_ram_sched.sv
// Bench for hist_ram_sched: behavioural pipeline_ram, histogram scoreboard and round-robin model.
module tb_hist_ram_sched;

  localparam int NREQ   = 2;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;
  localparam int RD_LAT = 3;
  localparam int NBINS  = 1 << ADDR_W;
  localparam int OUT_W  = NREQ + 6 + 2*ADDR_W + CNT_W;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*ADDR_W-1:0] req_bin;
  logic [NREQ-1:0]        req_ready;
  logic                   clr_start, dump_start;
  logic                   busy, done, ram_en, ram_clr, ram_rd;
  logic [ADDR_W-1:0]      ram_addr;
  logic [CNT_W-1:0]       ram_rdata;
  logic                   dump_valid;
  logic [ADDR_W-1:0]      dump_bin;
  logic [CNT_W-1:0]       dump_data;

  int total = 0;
  int bad   = 0;
  int exp_hist [NBINS];
  int exp_ptr;
  logic ram_wipe;

  logic [CNT_W-1:0] mem [NBINS];
  logic [CNT_W-1:0] rd_pipe [RD_LAT];

  wire [OUT_W-1:0] all_out = {req_ready, busy, done, ram_en, ram_clr, ram_rd, ram_addr,
                              dump_valid, dump_bin, dump_data};

  always #5 clk = ~clk;

  hist_ram_sched #(.NREQ(NREQ), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_bin(req_bin), .req_ready(req_ready),
    .clr_start(clr_start), .dump_start(dump_start), .busy(busy), .done(done),
    .ram_en(ram_en), .ram_clr(ram_clr), .ram_rd(ram_rd), .ram_addr(ram_addr),
    .ram_rdata(ram_rdata), .dump_valid(dump_valid), .dump_bin(dump_bin), .dump_data(dump_data)
  );

  // Behavioural RAM: increments land at once, reads return RD_LAT cycles later.
  always @(posedge clk) begin
    if (ram_wipe) begin
      for (int i = 0; i < NBINS; i++) mem[i] <= '0;
      for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= '0;
    end else begin
      if (ram_en) mem[ram_addr] <= mem[ram_addr] + 1'b1;
      else if (ram_clr) mem[ram_addr] <= '0;
      rd_pipe[0] <= ram_rd ? mem[ram_addr] : '0;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end
  assign ram_rdata = rd_pipe[RD_LAT-1];

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [OUT_W-1:0] pack_exp(
    input logic [NREQ-1:0] rdy, input logic bsy, input logic dn, input logic en,
    input logic clr, input logic rd, input logic [ADDR_W-1:0] addr, input logic dv,
    input logic [ADDR_W-1:0] db, input logic [CNT_W-1:0] dd);
    return {rdy, bsy, dn, en, clr, rd, addr, dv, db, dd};
  endfunction

  // Expected outputs of a RUN cycle; also advances the histogram and pointer model.
  task automatic model_grant(output logic [OUT_W-1:0] e, output int g);
    logic [ADDR_W-1:0] b;
    logic [NREQ-1:0]   oh;
    g = rr_pick(req_valid, exp_ptr);
    e = '0;
    if (g >= 0) begin
      b = req_bin[g*ADDR_W +: ADDR_W];
      oh = '0;
      oh[g] = 1'b1;
      e = pack_exp(oh, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, b, 1'b0, '0, '0);
      exp_hist[b] = exp_hist[b] + 1;
      exp_ptr = (g + 1) % NREQ;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_bin = '0; clr_start = 1'b0; dump_start = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    exp_ptr = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ram_wipe = 1'b1; req_valid = '1; req_bin = '1; clr_start = 1'b1; dump_start = 1'b0;
    for (int i = 0; i < NBINS; i++) exp_hist[i] = 0;
    exp_ptr = 0;
    for (int c = 0; c < 3; c++) begin
      cyc(); #1;
      total++;
      if (all_out !== '0) begin
        bad++; $display("FAIL reset c=%0d got=%h want=0", c, all_out);
      end
    end
    cyc();
    rst = 1'b0; ram_wipe = 1'b0; req_valid = '0; req_bin = '0; clr_start = 1'b0;
  endtask

  task automatic test_single();
    logic [OUT_W-1:0] e; int g;
    for (int c = 0; c < 4; c++) begin
      req_valid = 2'b01; req_bin = {5'd0, 5'd5};
      #1; model_grant(e, g);
      total++;
      if (all_out !== e) begin
        bad++; $display("FAIL single c=%0d got=%h want=%h", c, all_out, e);
      end
      cyc();
    end
    req_valid = '0;
  endtask

  task automatic test_alternate();
    logic [OUT_W-1:0] e; int g;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      req_valid = 2'b11; req_bin = {5'd6, 5'd1};
      #1; model_grant(e, g);
      total++;
      if (all_out !== e) begin
        bad++; $display("FAIL alternate c=%0d got=%h want=%h", c, all_out, e);
      end
      cyc();
    end
    req_valid = '0;
  endtask

  // Requesters raise at random and hold until granted.
  task automatic test_random();
    logic [OUT_W-1:0] e; int g; int last_g;
    last_g = -1;
    for (int c = 0; c < 200; c++) begin
      if (last_g >= 0) req_valid[last_g] = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
          req_valid[i] = 1'b1;
          req_bin[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, NBINS-1));
        end
      end
      #1; model_grant(e, g);
      total++;
      if (all_out !== e) begin
        bad++; $display("FAIL random c=%0d got=%h want=%h", c, all_out, e);
      end
      last_g = g;
      cyc();
    end
    req_valid = '0;
  endtask

  task automatic test_clear();
    logic [OUT_W-1:0] e; int g;
    clr_start = 1'b1; req_valid = 2'b11; req_bin = {5'd9, 5'd3};
    #1;
    total++;
    if (all_out !== '0) begin
      bad++; $display("FAIL clear_accept got=%h want=0", all_out);
    end
    cyc();
    clr_start = 1'b0;
    for (int t = 1; t <= 36; t++) begin
      dump_start = (t == 20);
      #1;
      if (t < 36) begin
        e = pack_exp('0, 1'b1, 1'b0, 1'b0, t >= 4, 1'b0,
                     (t >= 4) ? ADDR_W'(t - 4) : '0, 1'b0, '0, '0);
      end else begin
        for (int i = 0; i < NBINS; i++) exp_hist[i] = 0;
        model_grant(e, g);
        e = e | pack_exp('0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
      end
      total++;
      if (all_out !== e) begin
        bad++; $display("FAIL clear t=%0d got=%h want=%h", t, all_out, e);
      end
      cyc();
    end
    req_valid = '0;
  endtask

  task automatic test_dump();
    logic [OUT_W-1:0] e; int g; logic rd, dv; int bi;
    req_valid = 2'b01;
    for (int c = 0; c < 7; c++) begin
      req_bin = {5'd0, (c < 6) ? 5'd5 : 5'd11};
      #1; model_grant(e, g);
      total++;
      if (all_out !== e) begin
        bad++; $display("FAIL dump_fill c=%0d got=%h want=%h", c, all_out, e);
      end
      cyc();
    end
    req_valid = '0; dump_start = 1'b1;
    #1;
    total++;
    if (all_out !== '0) begin
      bad++; $display("FAIL dump_accept got=%h want=0", all_out);
    end
    cyc();
    dump_start = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      #1;
      rd = (t >= 4) && (t <= 35);
      dv = (t >= 7) && (t <= 38);
      bi = dv ? t - 7 : 0;
      e = pack_exp('0, t <= 38, t == 39, 1'b0, 1'b0, rd, rd ? ADDR_W'(t - 4) : '0,
                   dv, dv ? ADDR_W'(bi) : '0, dv ? CNT_W'(exp_hist[bi]) : '0);
      total++;
      if (all_out !== e) begin
        bad++; $display("FAIL dump t=%0d got=%h want=%h", t, all_out, e);
      end
      cyc();
    end
  endtask

  task automatic test_both();
    logic [OUT_W-1:0] e;
    clr_start = 1'b1; dump_start = 1'b1;
    #1;
    total++;
    if (all_out !== '0) begin
      bad++; $display("FAIL both_accept got=%h want=0", all_out);
    end
    cyc();
    clr_start = 1'b0; dump_start = 1'b0;
    for (int t = 1; t <= 44; t++) begin
      #1;
      e = pack_exp('0, t <= 35, t == 36, 1'b0, (t >= 4) && (t <= 35), 1'b0,
                   ((t >= 4) && (t <= 35)) ? ADDR_W'(t - 4) : '0, 1'b0, '0, '0);
      total++;
      if (all_out !== e) begin
        bad++; $display("FAIL both t=%0d got=%h want=%h", t, all_out, e);
      end
      cyc();
    end
    for (int i = 0; i < NBINS; i++) exp_hist[i] = 0;
  endtask

  task automatic test_rst_dump();
    logic [OUT_W-1:0] e; int g; int beats; logic hit;
    req_valid = 2'b01;
    for (int c = 0; c < 12; c++) begin
      req_bin = {5'd0, ADDR_W'($urandom_range(0, NBINS-1))};
      #1; model_grant(e, g);
      total++;
      if (all_out !== e) begin
        bad++; $display("FAIL rst_fill c=%0d got=%h want=%h", c, all_out, e);
      end
      cyc();
    end
    req_valid = '0; dump_start = 1'b1;
    cyc();
    dump_start = 1'b0;
    beats = 0; hit = 1'b0;
    for (int t = 0; t < 60 && !hit; t++) begin
      #1;
      if (dump_valid) begin
        beats++;
        total++;
        if ({dump_bin, dump_data} !== {ADDR_W'(beats - 1), CNT_W'(exp_hist[beats - 1])}) begin
          bad++; $display("FAIL rst_beat n=%0d got=%h/%h want=%0d/%0d",
                          beats, dump_bin, dump_data, beats - 1, exp_hist[beats - 1]);
        end
        if (beats == 10) begin
          rst = 1'b1; hit = 1'b1;
        end
      end
      if (!hit) cyc();
    end
    total++;
    if (!hit) begin
      bad++; $display("FAIL rst_wait got=%0d beats want=10", beats);
    end
    cyc();
    rst = 1'b0; exp_ptr = 0;
    for (int c = 0; c < 45; c++) begin
      #1;
      total++;
      if (all_out !== '0) begin
        bad++; $display("FAIL rst_quiet c=%0d got=%h want=0", c, all_out);
      end
      cyc();
    end
    req_valid = 2'b10; req_bin = {5'd7, 5'd0};
    #1; model_grant(e, g);
    total++;
    if (all_out !== e) begin
      bad++; $display("FAIL rst_regrant got=%h want=%h", all_out, e);
    end
    cyc();
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_random();
    test_clear();
    test_dump();
    test_both();
    test_rst_dump();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
